// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with load-use hazard detection and bubble insertion
module id_ex_latch #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_EX = 7,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_WB = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_DATA-1:0]    i_pc_plus4,
  input  logic [NB_DATA-1:0]    i_rd_data_1,
  input  logic [NB_DATA-1:0]    i_rd_data_2,
  input  logic [NB_DATA-1:0]    i_imm_ext,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic [NB_DATA-1:0]    o_pc_plus4,
  output logic [NB_DATA-1:0]    o_rd_data_1,
  output logic [NB_DATA-1:0]    o_rd_data_2,
  output logic [NB_DATA-1:0]    o_imm_ext,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_rd,
  output logic                  o_valid,
  output logic                  o_stall,
  output logic                  o_pc_write,
  output logic                  o_if_id_write
);
  logic [NB_CTRL_WB-1:0] r_wb;
  logic [NB_CTRL_M-1:0]  r_mem;
  logic [NB_CTRL_EX-1:0] r_exc;
  logic [NB_DATA-1:0]    r_pc_plus4, r_rd_data_1, r_rd_data_2, r_imm_ext;
  logic [NB_REG-1:0]     r_rs, r_rt, r_rd;
  logic                  r_valid;
  logic                  w_hazard, w_bubble;
  // Load in EX whose destination is a source of the ID instruction; $zero never hazards
  assign w_hazard = r_mem[1] & r_valid & (r_rt != '0) & ((r_rt == i_rs) | (r_rt == i_rt));
  assign o_stall = w_hazard & ~i_flush;
  assign o_pc_write = i_enable & ~o_stall;
  assign o_if_id_write = o_pc_write;
  assign w_bubble = i_flush | o_stall;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb        <= '0;
      r_mem       <= '0;
      r_exc       <= '0;
      r_pc_plus4  <= '0;
      r_rd_data_1 <= '0;
      r_rd_data_2 <= '0;
      r_imm_ext   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_valid     <= 1'b0;
    end else if (i_enable) begin
      r_wb        <= w_bubble ? '0 : i_ctrl_wb_bus;
      r_mem       <= w_bubble ? '0 : i_ctrl_mem_bus;
      r_exc       <= w_bubble ? '0 : i_ctrl_exc_bus;
      r_valid     <= ~w_bubble;
      r_pc_plus4  <= i_pc_plus4;
      r_rd_data_1 <= i_rd_data_1;
      r_rd_data_2 <= i_rd_data_2;
      r_imm_ext   <= i_imm_ext;
      r_rs        <= i_rs;
      r_rt        <= i_rt;
      r_rd        <= i_rd;
    end
  end
  assign o_ctrl_wb_bus  = r_wb;
  assign o_ctrl_mem_bus = r_mem;
  assign o_ctrl_exc_bus = r_exc;
  assign o_pc_plus4     = r_pc_plus4;
  assign o_rd_data_1    = r_rd_data_1;
  assign o_rd_data_2    = r_rd_data_2;
  assign o_imm_ext      = r_imm_ext;
  assign o_rs           = r_rs;
  assign o_rt           = r_rt;
  assign o_rd           = r_rd;
  assign o_valid        = r_valid;
endmodule
